// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, owner tags
// and the latched request bundle presented on the memory side.
package mem_arb_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_e;

    typedef struct packed {
        logic        wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin pick between core and debug requests.
// Latency: combinational. Backpressure: none, the caller decides when to use the grant.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic   core_req,
    input  logic   dbg_req,
    input  owner_e last_grant,
    output logic   grant,
    output owner_e owner
);

    // On a tie the master that was not served last wins.
    always_comb begin
        grant = core_req | dbg_req;
        owner = OWN_CORE;
        if (dbg_req && (!core_req || last_grant == OWN_CORE)) begin
            owner = OWN_DBG;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Core/debug arbiter and sequencer for the shared data-memory port, with access timeout.
// Latency: grant in IDLE, o_mem_req next cycle, ack two cycles after grant plus memory wait states.
// Backpressure: requesters hold req until their ack; requests seen in BUSY/DONE simply wait.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_core_req,
    input  logic        i_core_wren,
    input  logic [31:0] i_core_addr,
    input  logic [31:0] i_core_wdata,
    input  logic [3:0]  i_core_mask,
    output logic [31:0] o_core_rdata,
    output logic        o_core_ack,
    output logic        o_core_stall,
    input  logic        i_dbg_req,
    input  logic        i_dbg_wren,
    input  logic [31:0] i_dbg_addr,
    input  logic [31:0] i_dbg_wdata,
    input  logic [3:0]  i_dbg_mask,
    output logic [31:0] o_dbg_rdata,
    output logic        o_dbg_ack,
    output logic        o_mem_req,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_err
);

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

    arb_state_e        state_q, state_d;
    mem_req_t          req_q, req_d;
    owner_e            owner_q, owner_d;
    owner_e            last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              core_ack_q, core_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [31:0]       core_rdata_q, core_rdata_d;
    logic [31:0]       dbg_rdata_q, dbg_rdata_d;
    logic              err_q, err_d;

    logic              grant;
    owner_e            rr_owner;
    mem_req_t          core_fields, dbg_fields;
    logic              fin;
    logic              fin_err;
    logic [31:0]       fin_rdata;

    assign core_fields = '{wren: i_core_wren, addr: i_core_addr, wdata: i_core_wdata, mask: i_core_mask};
    assign dbg_fields  = '{wren: i_dbg_wren, addr: i_dbg_addr, wdata: i_dbg_wdata, mask: i_dbg_mask};

    mem_arb_rr u_rr (
        .core_req   (i_core_req),
        .dbg_req    (i_dbg_req),
        .last_grant (last_grant_q),
        .grant      (grant),
        .owner      (rr_owner)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        core_ack_d   = 1'b0;
        dbg_ack_d    = 1'b0;
        core_rdata_d = '0;
        dbg_rdata_d  = '0;
        err_d        = 1'b0;
        fin          = 1'b0;
        fin_err      = 1'b0;
        fin_rdata    = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    req_d        = (rr_owner == OWN_DBG) ? dbg_fields : core_fields;
                    owner_d      = rr_owner;
                    last_grant_d = rr_owner;
                    cnt_d        = '0;
                    mem_req_d    = 1'b1;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A memory ack in the final counted cycle still wins over the timeout.
                if (i_mem_ack) begin
                    fin       = 1'b1;
                    fin_rdata = req_q.wren ? 32'd0 : i_mem_rdata;
                end else if (cnt_q == TO_LIM) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (fin) begin
            mem_req_d = 1'b0;
            state_d   = ST_DONE;
            err_d     = fin_err;
            if (owner_q == OWN_DBG) begin
                dbg_ack_d   = 1'b1;
                dbg_rdata_d = fin_rdata;
            end else begin
                core_ack_d   = 1'b1;
                core_rdata_d = fin_rdata;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            owner_q      <= OWN_CORE;
            last_grant_q <= OWN_DBG;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            core_ack_q   <= 1'b0;
            dbg_ack_q    <= 1'b0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            core_ack_q   <= core_ack_d;
            dbg_ack_q    <= dbg_ack_d;
            core_rdata_q <= core_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            err_q        <= err_d;
        end
    end

    assign o_mem_req    = mem_req_q;
    assign o_mem_wren   = req_q.wren;
    assign o_mem_addr   = req_q.addr;
    assign o_mem_wdata  = req_q.wdata;
    assign o_mem_mask   = req_q.mask;
    assign o_core_ack   = core_ack_q;
    assign o_core_rdata = core_rdata_q;
    assign o_dbg_ack    = dbg_ack_q;
    assign o_dbg_rdata  = dbg_rdata_q;
    assign o_err        = err_q;
    assign o_core_stall = i_core_req & ~core_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level schedule model plus directed literal checks.
module tb_mem_arbiter;

    localparam int TO = 15;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_core_req, i_core_wren;
    logic [31:0] i_core_addr, i_core_wdata;
    logic [3:0]  i_core_mask;
    logic [31:0] o_core_rdata;
    logic        o_core_ack, o_core_stall;
    logic        i_dbg_req, i_dbg_wren;
    logic [31:0] i_dbg_addr, i_dbg_wdata;
    logic [3:0]  i_dbg_mask;
    logic [31:0] o_dbg_rdata;
    logic        o_dbg_ack;
    logic        o_mem_req, o_mem_wren;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;
    logic        o_err;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_core_req   (i_core_req),
        .i_core_wren  (i_core_wren),
        .i_core_addr  (i_core_addr),
        .i_core_wdata (i_core_wdata),
        .i_core_mask  (i_core_mask),
        .o_core_rdata (o_core_rdata),
        .o_core_ack   (o_core_ack),
        .o_core_stall (o_core_stall),
        .i_dbg_req    (i_dbg_req),
        .i_dbg_wren   (i_dbg_wren),
        .i_dbg_addr   (i_dbg_addr),
        .i_dbg_wdata  (i_dbg_wdata),
        .i_dbg_mask   (i_dbg_mask),
        .o_dbg_rdata  (o_dbg_rdata),
        .o_dbg_ack    (o_dbg_ack),
        .o_mem_req    (o_mem_req),
        .o_mem_wren   (o_mem_wren),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_mask   (o_mem_mask),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_ack    (i_mem_ack),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int miscompares = 0;

    // stimulus knobs
    int          p_core, p_dbg, wait_fixed, stray_mode;
    bit          rand_fields, scramble, rdata_fixed_en;
    logic [31:0] rdata_fixed;

    // transaction-level model: one access in flight, described by its grant/ack/done cycles
    int          cyc;
    bit          started;
    bit          have_txn, x_err, x_own_dbg, last_dbg;
    int          g_cyc, ack_cyc, done_cyc, free_at;
    logic        x_wren;
    logic [31:0] x_addr, x_wdata, x_rdata;
    logic [3:0]  x_mask;
    int          c_done_at, d_done_at;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic set_defaults();
        p_core = 0; p_dbg = 0; wait_fixed = 0; stray_mode = 0;
        rand_fields = 0; scramble = 0;
        rdata_fixed_en = 1; rdata_fixed = 32'hDEADBEEF;
    endtask

    task automatic model_reset();
        cyc = 0; started = 0; have_txn = 0; x_err = 0; x_own_dbg = 0; last_dbg = 1;
        g_cyc = 0; ack_cyc = -1; done_cyc = -1; free_at = 0;
        x_wren = 0; x_addr = 0; x_wdata = 0; x_mask = 0; x_rdata = 0;
        c_done_at = -1; d_done_at = -1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1; i_core_req = 1'b0; i_dbg_req = 1'b0; i_mem_ack = 1'b0;
        @(posedge i_clk); #1;
        chk("rst_mem_req",   32'(o_mem_req), 32'd0);
        chk("rst_mem_addr",  o_mem_addr, 32'd0);
        chk("rst_mem_mask",  32'(o_mem_mask), 32'd0);
        chk("rst_core_ack",  32'(o_core_ack), 32'd0);
        chk("rst_dbg_ack",   32'(o_dbg_ack), 32'd0);
        chk("rst_err",       32'(o_err), 32'd0);
        chk("rst_stall",     32'(o_core_stall), 32'd0);
        chk("rst_core_rd",   o_core_rdata, 32'd0);
        i_reset = 1'b0;
        model_reset();
    endtask

    task automatic step();
        bit c_cool, d_cool, pick_dbg, e_mem_req, e_c_ack, e_d_ack, e_err;
        int w;
        if (started) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        started = 1;
        c_cool = 0; d_cool = 0;

        // requesters drop req the cycle after their ack
        if (c_done_at >= 0 && cyc == c_done_at + 1) begin
            i_core_req = 1'b0; c_done_at = -1; c_cool = 1;
        end
        if (d_done_at >= 0 && cyc == d_done_at + 1) begin
            i_dbg_req = 1'b0; d_done_at = -1; d_cool = 1;
        end
        if (!i_core_req && !c_cool && $urandom_range(0, 99) < p_core) begin
            i_core_req = 1'b1;
            if (rand_fields) begin
                i_core_wren = 1'($urandom); i_core_addr = $urandom;
                i_core_wdata = $urandom; i_core_mask = 4'($urandom);
            end
        end else if (i_core_req && c_done_at >= 0 && scramble && $urandom_range(0, 3) == 0) begin
            i_core_wren = 1'($urandom); i_core_addr = $urandom;
            i_core_wdata = $urandom; i_core_mask = 4'($urandom);
        end
        if (!i_dbg_req && !d_cool && $urandom_range(0, 99) < p_dbg) begin
            i_dbg_req = 1'b1;
            if (rand_fields) begin
                i_dbg_wren = 1'($urandom); i_dbg_addr = $urandom;
                i_dbg_wdata = $urandom; i_dbg_mask = 4'($urandom);
            end
        end else if (i_dbg_req && d_done_at >= 0 && scramble && $urandom_range(0, 3) == 0) begin
            i_dbg_wren = 1'($urandom); i_dbg_addr = $urandom;
            i_dbg_wdata = $urandom; i_dbg_mask = 4'($urandom);
        end

        // memory side: ack exactly when the schedule says, strays only outside the busy window
        i_mem_rdata = rdata_fixed_en ? rdata_fixed : $urandom;
        e_mem_req = have_txn && cyc > g_cyc && cyc < done_cyc;
        if (have_txn && cyc == ack_cyc) begin
            i_mem_ack = 1'b1;
            x_rdata = x_wren ? 32'd0 : i_mem_rdata;
        end else if (e_mem_req) begin
            i_mem_ack = 1'b0;
        end else begin
            i_mem_ack = (stray_mode == 2) || (stray_mode == 1 && $urandom_range(0, 3) == 0);
        end

        e_c_ack = have_txn && cyc == done_cyc && !x_own_dbg;
        e_d_ack = have_txn && cyc == done_cyc && x_own_dbg;
        e_err   = have_txn && cyc == done_cyc && x_err;

        if (cyc >= free_at && (i_core_req || i_dbg_req)) begin
            pick_dbg = i_dbg_req && (!i_core_req || !last_dbg);
            if (wait_fixed >= 0) w = wait_fixed;
            else if ($urandom_range(0, 9) == 0) w = $urandom_range(TO, TO + 2);
            else w = $urandom_range(0, 4);
            have_txn = 1; g_cyc = cyc; last_dbg = pick_dbg; x_own_dbg = pick_dbg;
            x_err = (w > TO);
            if (x_err) begin
                ack_cyc = -1; done_cyc = cyc + 2 + TO; x_rdata = 32'd0;
            end else begin
                ack_cyc = cyc + 1 + w; done_cyc = cyc + 2 + w;
            end
            free_at = done_cyc + 1;
            if (pick_dbg) begin
                x_wren = i_dbg_wren; x_addr = i_dbg_addr; x_wdata = i_dbg_wdata; x_mask = i_dbg_mask;
                d_done_at = done_cyc;
            end else begin
                x_wren = i_core_wren; x_addr = i_core_addr; x_wdata = i_core_wdata; x_mask = i_core_mask;
                c_done_at = done_cyc;
            end
        end

        #3;
        chk("mem_req", 32'(o_mem_req), 32'(e_mem_req));
        if (e_mem_req) begin
            chk("mem_wren",  32'(o_mem_wren), 32'(x_wren));
            chk("mem_addr",  o_mem_addr, x_addr);
            chk("mem_wdata", o_mem_wdata, x_wdata);
            chk("mem_mask",  32'(o_mem_mask), 32'(x_mask));
        end
        chk("core_ack", 32'(o_core_ack), 32'(e_c_ack));
        chk("dbg_ack",  32'(o_dbg_ack), 32'(e_d_ack));
        chk("err",      32'(o_err), 32'(e_err));
        chk("stall",    32'(o_core_stall), 32'(i_core_req & ~e_c_ack));
        if (e_c_ack) begin
            chk("core_rdata", o_core_rdata, x_rdata);
            chk("dbg_rdata_nonowner", o_dbg_rdata, 32'd0);
        end
        if (e_d_ack) begin
            chk("dbg_rdata", o_dbg_rdata, x_rdata);
            chk("core_rdata_nonowner", o_core_rdata, 32'd0);
        end
    endtask

    task automatic run_to(input int c);
        while (!started || cyc < c) step();
    endtask

    initial begin
        i_reset = 1'b0;
        i_core_req = 0; i_core_wren = 0; i_core_addr = 0; i_core_wdata = 0; i_core_mask = 0;
        i_dbg_req = 0; i_dbg_wren = 0; i_dbg_addr = 0; i_dbg_wdata = 0; i_dbg_mask = 0;
        i_mem_rdata = 0; i_mem_ack = 0;
        set_defaults();
        model_reset();

        // core load, zero wait states
        do_reset();
        i_core_wren = 0; i_core_addr = 32'h10; i_core_wdata = 0; i_core_mask = 4'hF;
        p_core = 100;
        run_to(0); p_core = 0;
        chk("A_stall_c0", 32'(o_core_stall), 32'd1);
        chk("A_memreq_c0", 32'(o_mem_req), 32'd0);
        run_to(1);
        chk("A_memreq_c1", 32'(o_mem_req), 32'd1);
        chk("A_addr_c1", o_mem_addr, 32'h10);
        chk("A_stall_c1", 32'(o_core_stall), 32'd1);
        run_to(2);
        chk("A_ack_c2", 32'(o_core_ack), 32'd1);
        chk("A_rdata_c2", o_core_rdata, 32'hDEADBEEF);
        chk("A_stall_c2", 32'(o_core_stall), 32'd0);
        run_to(4);

        // both masters from reset, continuous: C,D,C,D
        set_defaults(); do_reset();
        p_core = 100; p_dbg = 100; rand_fields = 1;
        run_to(2); chk("B_core_ack_c2", 32'(o_core_ack), 32'd1);
        run_to(4); chk("B_dbg_memreq_c4", 32'(o_mem_req), 32'd1);
        run_to(5); chk("B_dbg_ack_c5", 32'(o_dbg_ack), 32'd1);
        run_to(8); chk("B_core_ack_c8", 32'(o_core_ack), 32'd1);
        run_to(11); chk("B_dbg_ack_c11", 32'(o_dbg_ack), 32'd1);
        run_to(30);

        // debug store with three wait states
        set_defaults(); do_reset();
        i_dbg_wren = 1; i_dbg_addr = 32'h7000; i_dbg_wdata = 32'h12345678; i_dbg_mask = 4'hF;
        p_dbg = 100; wait_fixed = 3;
        run_to(0); p_dbg = 0;
        for (int c = 1; c <= 4; c++) begin
            run_to(c);
            chk("C_memreq", 32'(o_mem_req), 32'd1);
            chk("C_addr", o_mem_addr, 32'h7000);
            chk("C_wdata", o_mem_wdata, 32'h12345678);
            chk("C_wren", 32'(o_mem_wren), 32'd1);
        end
        run_to(5);
        chk("C_dbg_ack_c5", 32'(o_dbg_ack), 32'd1);
        chk("C_core_ack_c5", 32'(o_core_ack), 32'd0);
        run_to(7);

        // timeout, then a normal access
        set_defaults(); do_reset();
        i_core_wren = 0; i_core_addr = 32'h40; i_core_mask = 4'hF;
        p_core = 100; wait_fixed = 100;
        run_to(0); p_core = 0;
        run_to(16); chk("D_no_ack_c16", 32'(o_core_ack), 32'd0);
        run_to(17);
        chk("D_ack_c17", 32'(o_core_ack), 32'd1);
        chk("D_err_c17", 32'(o_err), 32'd1);
        chk("D_rdata_c17", o_core_rdata, 32'd0);
        wait_fixed = 0; p_core = 100;
        run_to(21);
        chk("D_next_ack_c21", 32'(o_core_ack), 32'd1);
        chk("D_next_err_c21", 32'(o_err), 32'd0);
        p_core = 0;
        run_to(24);

        // reset while busy
        set_defaults(); do_reset();
        p_core = 100; wait_fixed = 5;
        run_to(0); p_core = 0;
        run_to(2); chk("E_busy_c2", 32'(o_mem_req), 32'd1);
        i_reset = 1'b1; #1;
        chk("E_rst_memreq", 32'(o_mem_req), 32'd0);
        chk("E_rst_ack", 32'(o_core_ack), 32'd0);
        do_reset();
        p_core = 100; wait_fixed = 0;
        run_to(0); p_core = 0;
        run_to(2); chk("E_after_ack_c2", 32'(o_core_ack), 32'd1);
        run_to(4);

        // stray acks in IDLE, and request fields changed while busy
        set_defaults(); do_reset();
        stray_mode = 2;
        run_to(3); chk("F_stray_noreq", 32'(o_mem_req), 32'd0);
        i_core_wren = 0; i_core_addr = 32'h10; i_core_mask = 4'hF;
        p_core = 100; wait_fixed = 2;
        run_to(4); p_core = 0;
        run_to(5); i_core_addr = 32'h20;
        run_to(6); chk("F_addr_latched", o_mem_addr, 32'h10);
        run_to(8); chk("F_ack_c8", 32'(o_core_ack), 32'd1);
        run_to(12);

        // randomized traffic, moderate then saturated load
        set_defaults(); do_reset();
        p_core = 40; p_dbg = 40; wait_fixed = -1; stray_mode = 1;
        rand_fields = 1; scramble = 1; rdata_fixed_en = 0;
        run_to(1500);
        p_core = 100; p_dbg = 100;
        run_to(2500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the shared data-memory/peripheral port. It sits between the processor's load/store path and the memory-mapped LSU, and lets a second master (debug/program loader) share that port. It runs a registered request/acknowledge transaction against a memory that may insert wait states, stalls the core while its access is outstanding, and bounds every access with a timeout.

## Interface
- `TIMEOUT_CYCLES`, default 15: BUSY cycles without `i_mem_ack` before the access is aborted; legal range 1..255.
- `i_clk` in 1: single clock, rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_core_req` in 1: core access request, held until `o_core_ack`.
- `i_core_wren` in 1: 1 = store, 0 = load.
- `i_core_addr` in 32: byte address.
- `i_core_wdata` in 32: store data.
- `i_core_mask` in 4: byte-lane enables.
- `o_core_rdata` out 32: load data, valid while `o_core_ack`=1.
- `o_core_ack` out 1: one-cycle completion pulse.
- `o_core_stall` out 1: freeze PC/register-file write; equals `i_core_req & ~o_core_ack`.
- `i_dbg_req`, `i_dbg_wren`, `i_dbg_addr`, `i_dbg_wdata`, `i_dbg_mask`, `o_dbg_rdata`, `o_dbg_ack`: same meanings and widths as the core set, for the debug master.
- `o_mem_req` out 1: memory request, held until `i_mem_ack` or timeout.
- `o_mem_wren` out 1: latched store enable.
- `o_mem_addr` out 32: latched address.
- `o_mem_wdata` out 32: latched store data.
- `o_mem_mask` out 4: latched byte-lane mask.
- `i_mem_rdata` in 32: memory read data, valid with `i_mem_ack`.
- `i_mem_ack` in 1: memory completion; ignored outside BUSY.
- `o_err` out 1: one-cycle pulse, coincident with the ack, when an access timed out.

## Operation
- FSM has three states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - With no request, stay in IDLE.
  - With one request, grant it.
  - With both requests, grant the master not served last (`last_grant` flag; reset value = dbg, so the core wins the first tie).
  - On grant: latch wren/addr/wdata/mask and the owner into registers, clear the timeout counter, update `last_grant`, and go to BUSY.
- BUSY:
  - `o_mem_*` are driven from the latched registers, with `o_mem_req`=1.
  - On `i_mem_ack`: capture `i_mem_rdata` (store: capture 0) and go to DONE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT_CYCLES`: set rdata to 0 and the error flag, then go to DONE.
- DONE:
  - Pulse the owner's ack with the captured rdata. `o_err` = error flag.
  - The other master's ack stays 0.
  - Go to IDLE unconditionally.
- Requesters hold `req` and all fields stable until ack, and drop `req` the cycle after ack. A `req` still high in IDLE is a new transaction.
- Request fields are sampled only at grant; later changes have no effect on the access in flight.
- Requests arriving in BUSY or DONE wait; they are never lost while held.
- The non-owner's `o_*_rdata` is 0.

## Timing
- Reset values (all asynchronous):
  - `o_mem_req`, `o_mem_wren`, both acks, `o_err`, `o_core_stall` = 0.
  - `o_mem_addr`, `o_mem_wdata`, rdata outputs = 0; `o_mem_mask` = 0.
  - Counter = 0; `last_grant` = dbg.
- Latency, memory ack in its first cycle:
  - Request seen in IDLE at cycle 0.
  - `o_mem_req` at cycle 1.
  - Ack at cycle 2.
  - Core stalls for 2 cycles.
- Latency with N memory wait states: ack at cycle 2+N.
- Timeout: ack and `o_err` at cycle 2+`TIMEOUT_CYCLES`.
- Back-to-back:
  - A waiting master is granted in the IDLE cycle right after DONE, giving one transaction per 3 cycles minimum.
  - Continuous dual requests alternate core/dbg strictly.
- Reset mid-transaction: `o_mem_req` drops immediately; no ack is issued; the FSM restarts in IDLE.
- All outputs are registered except `o_core_stall`.

## Structure
- Package `mem_arb_pkg`: FSM state enum; `mem_req_t` struct {wren, addr[31:0], wdata[31:0], mask[3:0]}; owner enum {OWN_CORE, OWN_DBG}.
- Sub-module `mem_arb_rr`: combinational round-robin pick from two requests plus `last_grant`, returning the grant and the owner.
- Top level holds the FSM, latch registers, timeout counter and response registers.

## Test plan
- Core load, addr 0x10, memory acks in the first BUSY cycle with 0xDEADBEEF → `o_mem_req` at cycle 1, `o_core_ack`=1 and `o_core_rdata`=0xDEADBEEF at cycle 2, `o_core_stall`=1 for cycles 0–1.
- Both masters request from reset, memory zero-wait → core acked at cycle 2, dbg `o_mem_req` at cycle 4 and acked at cycle 5; holding both requests continuously gives grant order C,D,C,D.
- Dbg store, addr 0x7000, wdata 0x12345678, mask 0xF, 3 wait states → `o_mem_*` stable with those values for 4 cycles, `o_dbg_ack` at cycle 5, `o_core_ack` stays 0.
- `i_mem_ack` never arrives, `TIMEOUT_CYCLES`=15 → `o_core_ack`=1, `o_err`=1, `o_core_rdata`=0 at cycle 17; the next request proceeds normally.
- `i_reset` asserted during BUSY → `o_mem_req`=0 in the same cycle, no ack; after release, a new core request completes with 2-cycle latency.
- Core changes addr 0x10→0x20 during BUSY, and a stray `i_mem_ack` is driven in IDLE → `o_mem_addr` stays 0x10, and the stray ack produces no grant or ack.
